// File: rtl/debounce_scheduler_if.sv
// debounce_scheduler_if: button-side bundle (raw inputs in, debounced levels/pulses/grant/busy out)
interface debounce_scheduler_if #(parameter int N_BTN = 4);
  logic [N_BTN-1:0] btn_raw, btn_level, btn_pulse, grant;
  logic busy;
  modport master (output btn_raw, input btn_level, btn_pulse, grant, busy);
  modport slave (input btn_raw, output btn_level, btn_pulse, grant, busy);
endinterface

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: N_BTN push-buttons debounced through one shared round-robin hold-off timer
// Ports: Clk, Reset (async, active-high); bus.btn_raw in; bus.btn_level, bus.btn_pulse, bus.grant, bus.busy out.
// Define DEBOUNCE_RELEASE_PULSE_EN to pulse btn_pulse on release commits as well as presses.
module debounce_scheduler #(
  parameter int N_BTN = 4,
  parameter int HOLD_CYCLES = 30000000,
  parameter int CNT_W = 25
) (
  input logic Clk,
  input logic Reset,
  debounce_scheduler_if.slave bus
);
  localparam int IW = $clog2(N_BTN);
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  localparam bit REL_PULSE = 1'b1;
`else
  localparam bit REL_PULSE = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, HOLD, COMMIT} state_t;
  state_t state_q;
  logic [N_BTN-1:0] sync1_q, sync_q, level_q, pulse_q, grant_q, req;
  logic [IW-1:0] last_q, w_q, win_d;
  logic sample_q;
  logic [CNT_W-1:0] cnt_q;
  assign req = sync_q ^ level_q;
  // Scan downward so the nearest pending index after last_q is the final assignment.
  always_comb begin
    win_d = last_q;
    for (int k = N_BTN; k >= 1; k--)
      if (req[(int'(last_q) + k) % N_BTN]) win_d = IW'((int'(last_q) + k) % N_BTN);
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      sync1_q <= '0;
      sync_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      grant_q <= '0;
      last_q <= IW'(N_BTN - 1);
      w_q <= '0;
      sample_q <= 1'b0;
      cnt_q <= '0;
      state_q <= IDLE;
    end else begin
      sync1_q <= bus.btn_raw;
      sync_q <= sync1_q;
      case (state_q)
        IDLE: if (|req) begin
          state_q <= HOLD;
          grant_q <= N_BTN'(1) << win_d;
          w_q <= win_d;
          sample_q <= sync_q[win_d];
          cnt_q <= '0;
        end
        HOLD: if (sync_q[w_q] != sample_q) begin
          state_q <= IDLE;
          grant_q <= '0;
          last_q <= w_q;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_q <= COMMIT;
          level_q[w_q] <= sample_q;
          pulse_q[w_q] <= REL_PULSE | sample_q;
        end else cnt_q <= cnt_q + CNT_W'(1);
        default: begin
          state_q <= IDLE;
          pulse_q <= '0;
          grant_q <= '0;
          last_q <= w_q;
        end
      endcase
    end
  assign bus.btn_level = level_q;
  assign bus.btn_pulse = pulse_q;
  assign bus.grant = grant_q;
  assign bus.busy = |grant_q;
endmodule

// File: doc/debounce_scheduler.md
# debounce_scheduler

- Multi-button debounce controller that shares one hold-off timer among `N_BTN` raw push-button inputs.
- Synchronizes each input and detects changes against a stable level.
- Grants the single timer to one pending button at a time (round-robin) and commits the new level only if the input stays steady for `HOLD_CYCLES`.
- Sits between the board push-buttons and the user logic; emits clean levels and one-cycle press pulses, replacing one timer per button with one timer total.

## Interface
- `N_BTN`, default 4: number of button inputs, 2..8.
- `HOLD_CYCLES`, default 30000000: required stable time in `Clk` cycles (300 ms at 100 MHz); must be ≥ 2.
- `CNT_W`, default 25: hold counter width; must satisfy 2^`CNT_W` > `HOLD_CYCLES`.
- `Clk` input, 1 bit: single clock, all logic rising-edge.
- `Reset` input, 1 bit: asynchronous, active-high reset.
- `btn_raw` input, `N_BTN` bits: raw, asynchronous button levels (1 = pressed).
- `btn_level` output, `N_BTN` bits: debounced stable levels, registered.
- `btn_pulse` output, `N_BTN` bits: one-cycle pulse per committed press, registered.
- `grant` output, `N_BTN` bits: one-hot owner of the shared timer; 0 when idle.
- `busy` output, 1 bit: high while the timer is owned (state HOLD or COMMIT).

## Operation
- **Synchronizer:** each `btn_raw[i]` passes through 2 flip-flops. `sync[i]` is the second stage.
- **Request:** `req[i] = (sync[i] != btn_level[i])`. This is combinational and re-evaluated every cycle.
- **State machine:** states IDLE, HOLD, COMMIT.
- **IDLE:**
  - If `req` ≠ 0, pick winner `w` by round-robin. Search starts at `last+1` and wraps modulo `N_BTN`, where `last` is the index of the last granted button.
  - Next state HOLD; `grant` <= onehot(`w`); `sample` <= `sync[w]`; `cnt` <= 0.
- **HOLD:**
  - If `sync[w] != sample`, the input bounced: go to IDLE, `grant` <= 0, `last` <= `w`, no level change.
  - Else if `cnt == HOLD_CYCLES-1`: go to COMMIT; `btn_level[w]` <= `sample`; `btn_pulse[w]` <= `sample`.
  - Otherwise `cnt` <= `cnt`+1.
- **COMMIT:** one cycle. `btn_pulse` <= 0, `grant` <= 0, `last` <= `w`, next state IDLE.
- **Unaffected inputs:** non-granted inputs that change while another button holds the timer keep `req` asserted and wait. Their changes are never lost, only delayed.
- **Glitch drop:** a request that disappears before being granted (input returned to `btn_level`) is dropped silently.
- **Pulse direction:** only 0→1 commits generate `btn_pulse`, unless the Configuration macro is defined. 1→0 commits update `btn_level` only.
- **Counter width:** `cnt` is `CNT_W` bits and never wraps; it is reset to 0 on every grant.
- **Reset values:** all outputs 0. Synchronizer flops 0, `sample` 0, `cnt` 0, state IDLE, `last` = `N_BTN`-1, so the first grant search starts at index 0.
- **Reset mid-HOLD:** aborts immediately and all outputs go to 0. Pressed buttons re-request after reset release; this is the required behaviour.

## Timing
- Raw change sampled at edge E0; `sync` valid after E1; `grant` asserted from E2 if IDLE.
- `btn_level` and `btn_pulse` update at edge E2+`HOLD_CYCLES`. `btn_pulse` is high exactly one cycle and falls at E2+`HOLD_CYCLES`+1.
- Back-to-back grants: IDLE takes 1 cycle after COMMIT. Minimum per-button service is `HOLD_CYCLES`+2 cycles.
- Worst-case wait for button i is (`N_BTN`-1)·(`HOLD_CYCLES`+2) cycles.
- `busy` equals OR of `grant`. At most one bit of `grant` and one bit of `btn_pulse` is high in any cycle.

## Configuration
- `DEBOUNCE_RELEASE_PULSE_EN` defined: COMMIT also pulses `btn_pulse[w]` on 1→0 commits (pulse on both press and release).
- `DEBOUNCE_RELEASE_PULSE_EN` undefined (default): pulses on press only.

## Test plan
(`N_BTN`=4, `HOLD_CYCLES`=8.)
- **Clean press:** hold `btn_raw`=4'b0001 from E0 → `grant`=0001 at E2; `btn_level`=0001 and `btn_pulse`=0001 at E10 only; `busy` low at E11.
- **Bounce:** `btn_raw[1]` toggles 1,0,1 with 3-cycle spacing, then holds 1 → first grant aborts (`grant` drops, `btn_level` unchanged). Final commit occurs 8 cycles after the last grant; exactly one pulse.
- **Contention:** `btn_raw`=4'b1111 simultaneously after reset → grants in order 0,1,2,3, each 10 cycles apart; 4 single pulses.
- **Release:** press then release button 2 → `btn_level[2]` returns 0 after `HOLD_CYCLES`. No pulse on release without `DEBOUNCE_RELEASE_PULSE_EN`; one pulse with it defined.
- **Reset mid-HOLD:** assert `Reset` at `cnt`=4 with button 3 held → all outputs 0 asynchronously. After release, button 3 is regranted at E2 and commits normally.
- **Glitch while busy:** button 1 in HOLD; button 0 pulses high 2 cycles → button 0 is never granted and its `btn_level` stays 0.
